multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 45 ++++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl_decode.sv | 28 ++
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// The TRAP state exists only when MULTICYCLE_CTRL_TRAP_EN is defined.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } instr_class_t;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_NOR  = 6'h01;
    localparam logic [5:0] OP_NOT  = 6'h02;
    localparam logic [5:0] OP_ROLV = 6'h03;
    localparam logic [5:0] OP_RORV = 6'h04;
    localparam logic [5:0] OP_NORI = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h06;
    localparam logic [5:0] OP_SW   = 6'h07;
    localparam logic [5:0] OP_BLEU = 6'h08;

    localparam logic [4:0] ALU_ADD  = 5'b10000;
    localparam logic [4:0] ALU_LW   = 5'b10001;
    localparam logic [4:0] ALU_SW   = 5'b10101;
    localparam logic [4:0] ALU_NOR  = 5'b10011;
    localparam logic [4:0] ALU_NORI = 5'b00111;
    localparam logic [4:0] ALU_NOT  = 5'b00010;
    localparam logic [4:0] ALU_BLEU = 5'b01000;
    localparam logic [4:0] ALU_ROLV = 5'b00000;
    localparam logic [4:0] ALU_RORV = 5'b00001;
    localparam logic [4:0] ALU_IDLE = 5'b11111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_ctrl_if #(
    parameter int RETIRE_W = 32
);
    logic [31:0]         instr;
    logic                bleu_take;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                addr_sel;
    logic                ir_we;
    logic                pc_we;
    logic                pc_src;
    logic [4:0]          alu_sel;
    logic                alu_src_imm;
    logic                reg_we;
    logic                mem_to_reg;
    logic                reg_dst_rt;
    logic [RETIRE_W-1:0] retired;
    logic                trap;

    modport master (
        input  instr, bleu_take, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_sel,
               alu_src_imm, reg_we, mem_to_reg, reg_dst_rt, retired, trap
    );

    modport slave (
        output instr, bleu_take, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_sel,
               alu_src_imm, reg_we, mem_to_reg, reg_dst_rt, retired, trap
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Opcode decoder: ALU selector, instruction class and illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   i_opcode,
    output logic [4:0]   o_alu_sel,
    output instr_class_t o_class,
    output logic         o_illegal
);
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_alu_sel = ALU_IDLE;
        o_class   = CLS_R;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_ADD:  o_alu_sel = ALU_ADD;
            OP_NOR:  o_alu_sel = ALU_NOR;
            OP_NOT:  o_alu_sel = ALU_NOT;
            OP_ROLV: o_alu_sel = ALU_ROLV;
            OP_RORV: o_alu_sel = ALU_RORV;
            OP_NORI: begin o_alu_sel = ALU_NORI; o_class = CLS_I;      end
            OP_LW:   begin o_alu_sel = ALU_LW;   o_class = CLS_LOAD;   end
            OP_SW:   begin o_alu_sel = ALU_SW;   o_class = CLS_STORE;  end
            OP_BLEU: begin o_alu_sel = ALU_BLEU; o_class = CLS_BRANCH; end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM sequencing FETCH/DECODE/EXEC/MEM/WB with a retired counter.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on illegal opcodes instead of retiring them as NOPs.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    import ctrl_pkg::*;

    state_t              r_state;
    state_t              w_next_state;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_retire;
    logic [4:0]          w_dec_alu_sel;
    instr_class_t        w_dec_class;
    logic                w_dec_illegal;

    ctrl_decode u_decode (
        .i_opcode  (bus.instr[31:26]),
        .o_alu_sel (w_dec_alu_sel),
        .o_class   (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH:  if (bus.mem_ready) w_next_state = ST_DECODE;
            ST_DECODE: begin
                if (w_dec_illegal) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    w_next_state = ST_TRAP;
`else
                    w_next_state = ST_FETCH;
                    w_retire     = 1'b1;
`endif
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_dec_class)
                    CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
                    CLS_BRANCH: begin
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                    default: w_next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (w_dec_class == CLS_STORE) begin
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_next_state = ST_FETCH;
                w_retire     = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            ST_TRAP: w_next_state = ST_TRAP;
`endif
            default: w_next_state = ST_FETCH;
        endcase
    end

    // Outputs are forced idle while reset is high so mem_req drops without waiting for a clock.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.addr_sel    = 1'b0;
        bus.ir_we       = 1'b0;
        bus.pc_we       = 1'b0;
        bus.pc_src      = 1'b0;
        bus.alu_sel     = ALU_IDLE;
        bus.alu_src_imm = 1'b0;
        bus.reg_we      = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst_rt  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.ir_we   = bus.mem_ready;
                    bus.pc_we   = bus.mem_ready;
                end
                ST_EXEC: begin
                    bus.alu_sel     = w_dec_alu_sel;
                    bus.alu_src_imm = (w_dec_class == CLS_I) || (w_dec_class == CLS_LOAD)
                                   || (w_dec_class == CLS_STORE);
                    if (w_dec_class == CLS_BRANCH) begin
                        bus.pc_we  = bus.bleu_take;
                        bus.pc_src = 1'b1;
                    end
                end
                ST_MEM: begin
                    bus.alu_sel  = w_dec_alu_sel;
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                    bus.mem_we   = (w_dec_class == CLS_STORE);
                end
                ST_WB: begin
                    bus.reg_we     = 1'b1;
                    bus.mem_to_reg = (w_dec_class == CLS_LOAD);
                    bus.reg_dst_rt = (w_dec_class == CLS_I) || (w_dec_class == CLS_LOAD);
                end
                default: ;
            endcase
        end
    end

    assign bus.retired = r_retired;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign bus.trap = (r_state == ST_TRAP);
`else
    assign bus.trap = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: a 32-bit and a 4-bit retire-counter instance run the same stimulus in lockstep.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        bleu_take;
    logic        mem_ready;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [31:0] I_ADD  = 32'h0000_0000;
    localparam logic [31:0] I_NORI = 32'h1400_0000;
    localparam logic [31:0] I_LW   = 32'h1800_0000;
    localparam logic [31:0] I_SW   = 32'h1C00_0000;
    localparam logic [31:0] I_BLEU = 32'h2000_0000;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;

    multicycle_ctrl_if #(.RETIRE_W(32)) if_w ();
    multicycle_ctrl_if #(.RETIRE_W(4))  if_n ();

    assign if_w.instr     = instr;
    assign if_w.bleu_take = bleu_take;
    assign if_w.mem_ready = mem_ready;
    assign if_n.instr     = instr;
    assign if_n.bleu_take = bleu_take;
    assign if_n.mem_ready = mem_ready;

    multicycle_ctrl #(.RETIRE_W(32)) u_dut_w (.clk(clk), .reset(reset), .bus(if_w.master));
    multicycle_ctrl #(.RETIRE_W(4))  u_dut_n (.clk(clk), .reset(reset), .bus(if_n.master));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; instr = I_ADD; bleu_take = 1'b0; mem_ready = 1'b0;
        #2;
        check("rst_mem_req", {31'd0, if_w.mem_req}, 32'd0);
        check("rst_alu_sel", {27'd0, if_w.alu_sel}, 32'h1F);
        check("rst_retired", if_w.retired, 32'd0);
        check("rst_trap",    {31'd0, if_w.trap}, 32'd0);
        check("rst_reg_we",  {31'd0, if_w.reg_we}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // ADD, memory ready immediately: FETCH, DECODE, EXEC, WB
        instr = I_ADD; mem_ready = 1'b1; settle();
        check("add_f_req",   {31'd0, if_w.mem_req}, 32'd1);
        check("add_f_irwe",  {31'd0, if_w.ir_we}, 32'd1);
        check("add_f_pcwe",  {31'd0, if_w.pc_we}, 32'd1);
        check("add_f_pcsrc", {31'd0, if_w.pc_src}, 32'd0);
        check("add_f_alu",   {27'd0, if_w.alu_sel}, 32'h1F);
        tick(); settle();
        check("add_d_req",   {31'd0, if_w.mem_req}, 32'd0);
        check("add_d_irwe",  {31'd0, if_w.ir_we}, 32'd0);
        check("add_d_alu",   {27'd0, if_w.alu_sel}, 32'h1F);
        tick(); settle();
        check("add_e_alu",   {27'd0, if_w.alu_sel}, 32'h10);
        check("add_e_regwe", {31'd0, if_w.reg_we}, 32'd0);
        check("add_e_imm",   {31'd0, if_w.alu_src_imm}, 32'd0);
        tick(); settle();
        check("add_w_regwe", {31'd0, if_w.reg_we}, 32'd1);
        check("add_w_m2r",   {31'd0, if_w.mem_to_reg}, 32'd0);
        check("add_w_rt",    {31'd0, if_w.reg_dst_rt}, 32'd0);
        check("add_w_ret",   if_w.retired, 32'd0);
        tick(); settle();
        check("add_ret",     if_w.retired, 32'd1);
        check("add_next_f",  {31'd0, if_w.mem_req}, 32'd1);

        // LW with two FETCH wait cycles and one MEM wait cycle: 8 cycles
        instr = I_LW; mem_ready = 1'b0; settle();
        check("lw_f0_req",   {31'd0, if_w.mem_req}, 32'd1);
        check("lw_f0_irwe",  {31'd0, if_w.ir_we}, 32'd0);
        tick(); settle();
        check("lw_f1_req",   {31'd0, if_w.mem_req}, 32'd1);
        tick(); mem_ready = 1'b1; settle();
        check("lw_f2_irwe",  {31'd0, if_w.ir_we}, 32'd1);
        tick(); settle();
        check("lw_d_req",    {31'd0, if_w.mem_req}, 32'd0);
        tick(); settle();
        check("lw_e_alu",    {27'd0, if_w.alu_sel}, 32'h11);
        check("lw_e_imm",    {31'd0, if_w.alu_src_imm}, 32'd1);
        tick(); mem_ready = 1'b0; settle();
        check("lw_m0_alu",   {27'd0, if_w.alu_sel}, 32'h11);
        check("lw_m0_req",   {31'd0, if_w.mem_req}, 32'd1);
        check("lw_m0_addr",  {31'd0, if_w.addr_sel}, 32'd1);
        check("lw_m0_we",    {31'd0, if_w.mem_we}, 32'd0);
        tick(); mem_ready = 1'b1; settle();
        check("lw_m1_req",   {31'd0, if_w.mem_req}, 32'd1);
        check("lw_m1_regwe", {31'd0, if_w.reg_we}, 32'd0);
        tick(); settle();
        check("lw_w_regwe",  {31'd0, if_w.reg_we}, 32'd1);
        check("lw_w_m2r",    {31'd0, if_w.mem_to_reg}, 32'd1);
        check("lw_w_rt",     {31'd0, if_w.reg_dst_rt}, 32'd1);
        tick(); settle();
        check("lw_ret",      if_w.retired, 32'd2);
        check("lw_next_f",   {31'd0, if_w.mem_req}, 32'd1);

        // SW: FETCH, DECODE, EXEC, MEM
        instr = I_SW; settle();
        tick(); tick(); settle();
        check("sw_e_alu",    {27'd0, if_w.alu_sel}, 32'h15);
        check("sw_e_imm",    {31'd0, if_w.alu_src_imm}, 32'd1);
        tick(); settle();
        check("sw_m_we",     {31'd0, if_w.mem_we}, 32'd1);
        check("sw_m_addr",   {31'd0, if_w.addr_sel}, 32'd1);
        check("sw_m_regwe",  {31'd0, if_w.reg_we}, 32'd0);
        tick(); settle();
        check("sw_ret",      if_w.retired, 32'd3);
        check("sw_f_regwe",  {31'd0, if_w.reg_we}, 32'd0);

        // BLEU taken, then not taken: 3 cycles each
        instr = I_BLEU; bleu_take = 1'b1; settle();
        tick(); tick(); settle();
        check("bt_e_alu",    {27'd0, if_w.alu_sel}, 32'h08);
        check("bt_e_pcwe",   {31'd0, if_w.pc_we}, 32'd1);
        check("bt_e_pcsrc",  {31'd0, if_w.pc_src}, 32'd1);
        tick(); bleu_take = 1'b0; settle();
        check("bt_ret",      if_w.retired, 32'd4);
        check("bt_f_req",    {31'd0, if_w.mem_req}, 32'd1);
        tick(); tick(); settle();
        check("bn_e_pcwe",   {31'd0, if_w.pc_we}, 32'd0);
        check("bn_e_pcsrc",  {31'd0, if_w.pc_src}, 32'd1);
        tick(); settle();
        check("bn_ret",      if_w.retired, 32'd5);

        // Illegal opcode 3F
        instr = I_ILL; settle();
        tick(); settle();
        check("ill_d_trap",  {31'd0, if_w.trap}, 32'd0);
        tick(); settle();
`ifdef MULTICYCLE_CTRL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            check("ill_trap",    {31'd0, if_w.trap}, 32'd1);
            check("ill_t_req",   {31'd0, if_w.mem_req}, 32'd0);
            check("ill_t_ret",   if_w.retired, 32'd5);
            tick(); settle();
        end
`else
        check("ill_trap",    {31'd0, if_w.trap}, 32'd0);
        check("ill_f_req",   {31'd0, if_w.mem_req}, 32'd1);
        check("ill_ret",     if_w.retired, 32'd6);
`endif
        reset = 1'b1; settle();
        check("ill_rst_trap", {31'd0, if_w.trap}, 32'd0);
        check("ill_rst_ret",  if_w.retired, 32'd0);
        tick(); reset = 1'b0; settle();

        // Reset asserted in MEM of a LW
        instr = I_LW; mem_ready = 1'b1; settle();
        tick(); tick(); mem_ready = 1'b0; tick(); settle();
        check("lwr_m_req",   {31'd0, if_w.mem_req}, 32'd1);
        reset = 1'b1; settle();
        check("lwr_req",     {31'd0, if_w.mem_req}, 32'd0);
        check("lwr_regwe",   {31'd0, if_w.reg_we}, 32'd0);
        check("lwr_alu",     {27'd0, if_w.alu_sel}, 32'h1F);
        tick(); settle();
        check("lwr_hold_req", {31'd0, if_w.mem_req}, 32'd0);
        reset = 1'b0; settle();
        check("lwr_f_req",   {31'd0, if_w.mem_req}, 32'd1);
        check("lwr_f_addr",  {31'd0, if_w.addr_sel}, 32'd0);
        check("lwr_ret",     if_w.retired, 32'd0);

        // 16 NORI: 4-bit counter wraps to 0, 32-bit counter reaches 16
        instr = I_NORI; mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick(); tick(); settle();
            check("nori_e_alu", {27'd0, if_w.alu_sel}, 32'h07);
            check("nori_e_imm", {31'd0, if_w.alu_src_imm}, 32'd1);
            tick(); settle();
            check("nori_w_rt",  {31'd0, if_w.reg_dst_rt}, 32'd1);
            tick(); settle();
            if (n == 14) check("nori_n_max", {28'd0, if_n.retired}, 32'hF);
        end
        check("nori_w_ret",  if_w.retired, 32'd16);
        check("nori_n_wrap", {28'd0, if_n.retired}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
